// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep sequencer for the DDS core.
// Drives the phase increment and the accumulator controls.
module dds_sweep_ctrl #(
  parameter int M = 16,
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [1:0]   mode,
  input  logic [M-1:0] p_start,
  input  logic [M-1:0] p_stop,
  input  logic [M-1:0] p_step,
  input  logic [D-1:0] dwell,
  output logic [M-1:0] P,
  output logic         rst_ac,
  output logic         ena_ac,
  output logic         val_in,
  output logic         dir,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    FIN
  } state_t;

  state_t state, state_n;

  logic [M-1:0] c_start, c_stop, c_step;
  logic [D-1:0] c_dwell;
  logic [1:0]   c_mode;
  logic [D-1:0] cnt, cnt_n;
  logic         ld;

  logic [M-1:0] p_n;
  logic         rst_ac_n, ena_n, val_n;
  logic         dir_n, busy_n, done_n, err_n;

  logic         cfg_bad;
  logic         step_ev;
  logic         at_top, at_bot;
  logic         leg_end;
  logic [M:0]   up_sum, dn_diff;
  logic [M-1:0] up_next, dn_next;

  assign cfg_bad = (p_start > p_stop) || (p_step == '0);
  assign step_ev = (cnt == c_dwell);
  assign at_top  = (P == c_stop);
  assign at_bot  = (P == c_start);
  assign leg_end = dir ? at_bot : (at_top && !c_mode[1]);

  // One extra bit catches carry-out and borrow.
  assign up_sum  = {1'b0, P} + {1'b0, c_step};
  assign dn_diff = {1'b0, P} - {1'b0, c_step};

  assign up_next = (up_sum >= {1'b0, c_stop}) ?
                   c_stop : up_sum[M-1:0];
  assign dn_next = (dn_diff[M] || dn_diff[M-1:0] <= c_start) ?
                   c_start : dn_diff[M-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      P       <= '0;
      rst_ac  <= 1'b0;
      ena_ac  <= 1'b0;
      val_in  <= 1'b0;
      dir     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
      c_start <= '0;
      c_stop  <= '0;
      c_step  <= '0;
      c_dwell <= '0;
      c_mode  <= '0;
    end else begin
      state  <= state_n;
      P      <= p_n;
      rst_ac <= rst_ac_n;
      ena_ac <= ena_n;
      val_in <= val_n;
      dir    <= dir_n;
      busy   <= busy_n;
      done   <= done_n;
      err    <= err_n;
      cnt    <= cnt_n;
      if (ld) begin
        c_start <= p_start;
        c_stop  <= p_stop;
        c_step  <= p_step;
        c_dwell <= dwell;
        c_mode  <= mode;
      end
    end
  end

  // Outputs are computed for the state being entered.
  always_comb begin
    state_n  = state;
    p_n      = P;
    dir_n    = dir;
    cnt_n    = cnt;
    rst_ac_n = 1'b0;
    ena_n    = 1'b0;
    val_n    = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    ld       = 1'b0;
    if (abort) begin
      state_n = IDLE;
      p_n     = '0;
      dir_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err_n = 1'b1;
            end else begin
              ld       = 1'b1;
              state_n  = CLEAR;
              rst_ac_n = 1'b1;
              busy_n   = 1'b1;
              p_n      = p_start;
              dir_n    = 1'b0;
              cnt_n    = '0;
            end
          end
        end
        CLEAR: begin
          state_n = RUN;
          ena_n   = 1'b1;
          val_n   = 1'b1;
          busy_n  = 1'b1;
        end
        RUN: begin
          ena_n  = 1'b1;
          val_n  = 1'b1;
          busy_n = 1'b1;
          if (!step_ev) begin
            cnt_n = cnt + 1'b1;
          end else begin
            cnt_n = '0;
            unique case (1'b1)
              leg_end: begin
                if (c_mode[0]) begin
                  p_n   = c_start;
                  dir_n = 1'b0;
                end else begin
                  state_n = FIN;
                  ena_n   = 1'b0;
                  val_n   = 1'b0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                end
              end
              (!dir && at_top && c_mode[1]): begin
                dir_n = 1'b1;
                p_n   = dn_next;
              end
              (!dir && !at_top): p_n = up_next;
              (dir && !at_bot):  p_n = dn_next;
            endcase
          end
        end
        FIN: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed and random sweeps
// checked against a step-list model of the sweep.
module tb_dds_sweep_ctrl;

  localparam int M = 16;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst, start, abort;
  logic [1:0]   mode;
  logic [M-1:0] p_start, p_stop, p_step;
  logic [D-1:0] dwell;
  logic [M-1:0] P;
  logic         rst_ac, ena_ac, val_in, dir, busy, done, err;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.M(M), .D(D)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mode(mode), .p_start(p_start), .p_stop(p_stop),
    .p_step(p_step), .dwell(dwell), .P(P),
    .rst_ac(rst_ac), .ena_ac(ena_ac), .val_in(val_in),
    .dir(dir), .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] last_p = '0;
  logic        last_dir = 1'b0;

  typedef struct packed {
    logic [15:0] p;
    logic        d;
  } ent_t;
  ent_t seq[$];

  logic [22:0] obs;
  assign obs = {P, rst_ac, ena_ac, val_in, dir, busy, done, err};

  function automatic logic [22:0] pk(
    logic [15:0] p, logic r, logic e, logic v,
    logic d, logic b, logic dn, logic er);
    return {p, r, e, v, d, b, dn, er};
  endfunction

  task automatic chk(string tag, logic [22:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed P=%h rst/ena/val/dir/busy/done/err=%b expected P=%h flags=%b",
             tag, obs[22:7], obs[6:0], exp[22:7], exp[6:0]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(int v, bit d, int dw);
    ent_t e;
    e.p = v[15:0];
    e.d = d;
    for (int r = 0; r <= dw; r++) seq.push_back(e);
  endtask

  // Sweep as the list of P values, each held dwell+1 cycles.
  task automatic build(int s, int e, int st, int dw, bit tri_m);
    int v;
    seq.delete();
    v = s;
    push(v, 1'b0, dw);
    while (v != e) begin
      v = (v + st >= e) ? e : v + st;
      push(v, 1'b0, dw);
    end
    if (tri_m) begin
      do begin
        v = (v - st <= s) ? s : v - st;
        push(v, 1'b1, dw);
      end while (v != s);
    end
  endtask

  task automatic sweep(string tag, int s, int e, int st, int dw,
                       logic [1:0] md, int stop_at, bit use_rst);
    ent_t l;
    p_start = s[15:0];
    p_stop  = e[15:0];
    p_step  = st[15:0];
    dwell   = dw[15:0];
    mode    = md;
    start   = 1'b1;
    tick;
    start   = 1'b0;
    p_start = 16'($urandom);
    p_stop  = 16'($urandom);
    p_step  = 16'($urandom);
    dwell   = 16'($urandom_range(0, 3));
    mode    = 2'($urandom);
    chk({tag, ":clear"}, pk(s[15:0], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    build(s, e, st, dw, md[1]);
    for (int k = 0; ; k++) begin
      if (stop_at >= 0 && k == stop_at) begin
        start = 1'b0;
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
        tick;
        rst   = 1'b0;
        abort = 1'b0;
        chk({tag, ":stop"}, '0);
        tick;
        chk({tag, ":stop_idle"}, '0);
        last_p   = '0;
        last_dir = 1'b0;
        return;
      end
      if (!md[0] && k == seq.size()) begin
        l = seq[seq.size()-1];
        start = 1'b0;
        tick;
        chk({tag, ":fin"}, pk(l.p, 1'b0, 1'b0, 1'b0, l.d, 1'b0, 1'b1, 1'b0));
        tick;
        chk({tag, ":idle"}, pk(l.p, 1'b0, 1'b0, 1'b0, l.d, 1'b0, 1'b0, 1'b0));
        last_p   = l.p;
        last_dir = l.d;
        return;
      end
      start = 1'($urandom_range(0, 1));
      tick;
      l = seq[k % seq.size()];
      chk({tag, ":run"}, pk(l.p, 1'b0, 1'b1, 1'b1, l.d, 1'b1, 1'b0, 1'b0));
    end
  endtask

  task automatic bad(string tag, int s, int e, int st);
    p_start = s[15:0];
    p_stop  = e[15:0];
    p_step  = st[15:0];
    start   = 1'b1;
    tick;
    start   = 1'b0;
    chk({tag, ":err"}, pk(last_p, 1'b0, 1'b0, 1'b0, last_dir, 1'b0, 1'b0, 1'b1));
    tick;
    chk({tag, ":after"}, pk(last_p, 1'b0, 1'b0, 1'b0, last_dir, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    int s, e, st, dw, sa;
    logic [1:0] md;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode = '0;
    p_start = '0;
    p_stop = '0;
    p_step = '0;
    dwell = '0;
    tick;
    tick;
    chk("reset", '0);
    rst = 1'b0;
    tick;
    chk("reset_idle", '0);

    sweep("up", 100, 400, 100, 3, 2'b00, -1, 1'b0);
    sweep("clamp", 100, 400, 150, 3, 2'b00, -1, 1'b0);
    sweep("tri", 100, 300, 100, 0, 2'b10, -1, 1'b0);
    sweep("cont", 10, 30, 10, 1, 2'b01, 7, 1'b0);
    bad("inv_order", 500, 400, 10);
    bad("inv_step", 100, 400, 0);

    p_start = 16'd100;
    p_stop  = 16'd400;
    p_step  = 16'd100;
    start   = 1'b1;
    abort   = 1'b1;
    tick;
    start   = 1'b0;
    abort   = 1'b0;
    chk("start_abort", '0);
    last_p   = '0;
    last_dir = 1'b0;
    tick;
    chk("start_abort_idle", '0);

    sweep("carry", 16'hFF00, 16'hFFF0, 16'h0100, 0, 2'b00, -1, 1'b0);
    sweep("eq_single", 200, 200, 5, 2, 2'b00, -1, 1'b0);
    sweep("eq_tri", 200, 200, 5, 1, 2'b10, -1, 1'b0);
    sweep("tri_cont", 100, 300, 100, 0, 2'b11, 17, 1'b0);
    sweep("rst_run", 100, 400, 100, 3, 2'b00, 6, 1'b1);
    sweep("abort_single", 100, 400, 100, 1, 2'b10, 5, 1'b0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s  = $urandom_range(16'hF000, 16'hFFFF);
        e  = $urandom_range(s, 16'hFFFF);
        st = $urandom_range(16'h0200, 16'h3000);
      end else begin
        s  = $urandom_range(0, 2000);
        e  = s + $urandom_range(0, 1500);
        st = $urandom_range(80, 700);
      end
      dw = $urandom_range(0, 3);
      md = 2'($urandom_range(0, 3));
      if (md[0]) sa = $urandom_range(1, 80);
      else if ($urandom_range(0, 4) == 0) sa = $urandom_range(1, 10);
      else sa = -1;
      sweep("rand", s, e, st, dw, md, sa, 1'($urandom_range(0, 1)));
      if (i % 4 == 0) bad("rand_bad", 1000 + i, 999, 7);
      if (i % 4 == 2) bad("rand_zero", i, 900, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Sequencer that drives the phase-increment input P and the accumulator controls (rst_ac, ena_ac, val_in) of the DDS core.
- Produces linear frequency sweeps: stepped up, or triangle up/down, single-shot or continuous, with a programmable dwell per step.
- Sits between the register/host interface and the DDS datapath.
- Configuration is latched at start, so host registers may change during a sweep.

Parameters:
- M, 16, phase-accumulator width; width of P and of all frequency words.
- D, 16, dwell counter width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  stop immediately from any state.
- mode  in  2  bit0 = continuous repeat; bit1 = triangle (up then down).
- p_start  in  M  first (lowest) phase increment, unsigned.
- p_stop  in  M  last (highest) phase increment, unsigned.
- p_step  in  M  increment between steps, unsigned.
- dwell  in  D  each P value is held for dwell+1 cycles.
- P  out  M  phase increment to the DDS.
- rst_ac  out  1  accumulator clear to the DDS.
- ena_ac  out  1  accumulator enable to the DDS.
- val_in  out  1  sample-valid to the DDS.
- dir  out  1  0 = ascending, 1 = descending.
- busy  out  1  high in CLEAR and RUN.
- done  out  1  one-cycle pulse at the end of a single-shot sweep.
- err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset mid-sweep returns to IDLE on the next edge with no done pulse.
- All outputs are registered.
- FSM states: IDLE, CLEAR, RUN, FIN.
- IDLE, start=1, abort=0:
  - Config is invalid if p_start > p_stop or p_step == 0. Then: err=1 for one cycle, stay in IDLE.
  - Otherwise latch p_start, p_stop, p_step, dwell and mode, then go to CLEAR.
- abort has priority over start in all states.
- CLEAR (exactly 1 cycle): rst_ac=1, ena_ac=0, val_in=0, P=p_start, dir=0, busy=1, dwell counter=0. Next state is RUN.
- RUN: ena_ac=1, val_in=1, busy=1, rst_ac=0. The dwell counter increments every cycle. When the counter equals the latched dwell, it resets to 0 and a step event occurs.
- Step event, ascending (dir=0):
  - If P == p_stop: end of up-leg (see below).
  - Else compute P + p_step in M+1 bits. If the sum >= p_stop (including carry-out), P <= p_stop; otherwise P <= sum.
- Step event, descending (dir=1):
  - If P == p_start: end of sweep.
  - Else, if P - p_step <= p_start or it underflows (compare in M+1 bits), P <= p_start; otherwise P <= P - p_step.
- End of up-leg:
  - Triangle mode: dir <= 1, P <= P - p_step, clamped to p_start as above.
  - Otherwise: end of sweep.
- End of sweep:
  - Continuous mode: P <= p_start, dir <= 0, stay in RUN. No accumulator clear, no done.
  - Single-shot: go to FIN.
- FIN (1 cycle): done=1, ena_ac=0, val_in=0, busy=0, P held. Next state is IDLE.
- p_start == p_stop is valid:
  - Single-shot: one step of dwell+1 cycles, then FIN.
  - Triangle: the up-leg ends at once. The down-leg starts at p_start and therefore ends at its first step event.
- IDLE: ena_ac=0, val_in=0, P holds its last value (0 after reset).
- abort in any state: next cycle IDLE with ena_ac=0, val_in=0, busy=0, P=0, dir=0, and no done pulse.
- start while busy is ignored.
- Latency: start at edge n gives rst_ac=1 in cycle n+1. The first valid RUN cycle with P=p_start is n+2.

Test Plan:
- Single-shot up, p_start=100, p_stop=400, p_step=100, dwell=3:
  - P = 100, 200, 300, 400, each for 4 cycles (16 RUN cycles).
  - Then done for 1 cycle, then busy=0.
- Clamp, same as above but p_step=150: P = 100, 250, 400 (4 cycles each). Then FIN.
- Triangle single-shot, p_start=100, p_stop=300, p_step=100, dwell=0:
  - P = 100, 200, 300, 200, 100, one cycle each.
  - dir rises on the first 200 of the down-leg.
  - Then done.
- Continuous, p_start=10, p_stop=30, p_step=10, dwell=1:
  - P = 10,10,20,20,30,30,10,10,… with no rst_ac after CLEAR.
  - Abort mid-step: next cycle P=0, ena_ac=0, done never asserted.
- Invalid config:
  - p_start=500, p_stop=400 → err pulse, busy stays 0.
  - p_step=0 → err pulse, busy stays 0.
  - start together with abort in IDLE → no err, no busy.
- Overflow and reset:
  - M=16, p_start=0xFF00, p_stop=0xFFF0, p_step=0x0100 → P = 0xFF00 then 0xFFF0 (carry clamp).
  - rst asserted in RUN → next cycle all outputs 0, FSM in IDLE.
